// File: rtl/vram_arbiter_if.sv
// vram_arbiter_if -- single-port VRAM bus between the arbiter and the memory.
//   vram_addr  : word address of the access issued this cycle
//   vram_re    : read strobe; vram_rdata is valid on the following cycle
//   vram_we    : write strobe; vram_wdata is written at vram_addr
//   vram_wdata : write data
//   vram_rdata : read data returned by the memory
// The master modport belongs to the arbiter and the slave modport to the memory.
interface vram_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic [AW-1:0] vram_addr;
  logic          vram_re;
  logic          vram_we;
  logic [DW-1:0] vram_wdata;
  logic [DW-1:0] vram_rdata;

  modport master (
    output vram_addr, vram_re, vram_we, vram_wdata,
    input  vram_rdata
  );

  modport slave (
    input  vram_addr, vram_re, vram_we, vram_wdata,
    output vram_rdata
  );
endinterface

// File: rtl/vram_arbiter.sv
// vram_arbiter -- shares one VRAM port between render fetches, CPU accesses
// through auto-incrementing pointers, and a block-copy DMA engine.
// The port carries at most one access per cycle.
// Fixed priority: render > CPU write > CPU read > DMA.
// Ports:
//   clock, reset        : rising-edge clock; asynchronous active-high reset
//   render_*            : combinational render fetch; its read data is dropped
//   mawr_*, cpu_wr_*    : write pointer load and a 1-entry write buffer
//   marr_*, cpu_rd_ack  : read pointer load/advance; each one queues a prefetch
//   vrr_data            : last word the CPU prefetched
//   incr_sel            : pointer step (00=1, 01=32, 10=64, 11=128)
//   busy_n              : low while a CPU access or its data return is outstanding
//   dma_*               : block copy of dma_len+1 words; src/dst step by +/-1
//   vram                : VRAM bus (master side)
module vram_arbiter #(
  parameter int AW = 16,
  parameter int DW = 16
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          render_req,
  input  logic [AW-1:0] render_addr,
  output logic          render_grant,
  input  logic          mawr_ld,
  input  logic [AW-1:0] mawr_in,
  input  logic          cpu_wr_req,
  input  logic [DW-1:0] cpu_wr_data,
  input  logic          marr_ld,
  input  logic [AW-1:0] marr_in,
  input  logic          cpu_rd_ack,
  output logic [DW-1:0] vrr_data,
  input  logic [1:0]    incr_sel,
  output logic          busy_n,
  input  logic          dma_start,
  input  logic [AW-1:0] dma_src,
  input  logic [AW-1:0] dma_dst,
  input  logic [AW-1:0] dma_len,
  input  logic          dma_src_dec,
  input  logic          dma_dst_dec,
  output logic          dma_busy,
  output logic          dma_done,
  vram_arbiter_if.master vram
);

  typedef enum logic [2:0] {IDLE, READ, CAPT, WRITE, DONE} dma_state_t;

  dma_state_t    state, state_nx;
  logic [AW-1:0] step;
  logic [AW-1:0] mawr, marr;
  logic [DW-1:0] wr_buf;
  logic          wr_pending, rd_pending;
  logic          ret_tag;      // 1: this cycle's read data belongs to the CPU
  logic [AW-1:0] src, dst, cnt;
  logic [DW-1:0] dma_buf;
  logic          wr_grant, rd_grant, dma_grant, dma_wr_go;

  // NOTE: every always_comb output gets a default first, so no path can leave
  // a signal unassigned and infer a latch.
  always_comb begin
    step = AW'(1);
    unique case (incr_sel)
      2'b00:   step = AW'(1);
      2'b01:   step = AW'(32);
      2'b10:   step = AW'(64);
      default: step = AW'(128);
    endcase
  end

  // Priority chain. Each lower requester sees the port only when all higher
  // requesters are idle.
  assign render_grant = render_req;
  assign wr_grant     = !render_req && wr_pending;
  assign rd_grant     = !render_req && !wr_pending && rd_pending;
  assign dma_grant    = !render_req && !wr_pending && !rd_pending &&
                        ((state == READ) || (state == WRITE));

  assign busy_n   = !(wr_pending || rd_pending || ret_tag);
  assign dma_busy = (state != IDLE);

  // VRAM port mux. An idle port drives all zeros.
  always_comb begin
    vram.vram_addr  = '0;
    vram.vram_re    = 1'b0;
    vram.vram_we    = 1'b0;
    vram.vram_wdata = '0;
    if (render_grant) begin
      vram.vram_re   = 1'b1;
      vram.vram_addr = render_addr;
    end else if (wr_grant) begin
      vram.vram_we    = 1'b1;
      vram.vram_addr  = mawr;
      vram.vram_wdata = wr_buf;
    end else if (rd_grant) begin
      vram.vram_re   = 1'b1;
      vram.vram_addr = marr;
    end else if (dma_grant) begin
      if (state == READ) begin
        vram.vram_re   = 1'b1;
        vram.vram_addr = src;
      end else begin
        vram.vram_we    = 1'b1;
        vram.vram_addr  = dst;
        vram.vram_wdata = dma_buf;
      end
    end
  end

  // CPU write pointer and 1-entry write buffer. A request that arrives while
  // the buffer is full is dropped. A pointer load overrides the post-write
  // increment, so a write still pending goes to the newly loaded address.
  // NOTE: state registers use non-blocking assignments, so every flop samples
  // values from before the edge regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mawr       <= '0;
      wr_buf     <= '0;
      wr_pending <= 1'b0;
    end else begin
      if (mawr_ld)       mawr <= mawr_in;
      else if (wr_grant) mawr <= mawr + step;

      if (wr_pending) begin
        if (wr_grant) wr_pending <= 1'b0;
      end else if (cpu_wr_req) begin
        wr_buf     <= cpu_wr_data;
        wr_pending <= 1'b1;
      end
    end
  end

  // CPU read pointer and prefetch. A new request in the same cycle as a
  // service re-arms the prefetch, so the prefetch uses the new pointer.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      marr       <= '0;
      rd_pending <= 1'b0;
      ret_tag    <= 1'b0;
      vrr_data   <= '0;
    end else begin
      if (marr_ld) begin
        marr       <= marr_in;
        rd_pending <= 1'b1;
      end else if (cpu_rd_ack) begin
        marr       <= marr + step;
        rd_pending <= 1'b1;
      end else if (rd_grant) begin
        rd_pending <= 1'b0;
      end
      ret_tag <= rd_grant;
      if (ret_tag) vrr_data <= vram.vram_rdata;
    end
  end

  // DMA engine: state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // DMA engine: next-state and strobes.
  always_comb begin
    state_nx  = state;
    dma_wr_go = 1'b0;
    dma_done  = 1'b0;
    unique case (state)
      IDLE:  if (dma_start) state_nx = READ;
      READ:  if (dma_grant) state_nx = CAPT;
      CAPT:  state_nx = WRITE;
      WRITE: if (dma_grant) begin
               dma_wr_go = 1'b1;
               state_nx  = (cnt == '0) ? DONE : READ;
             end
      DONE:  begin
               dma_done = 1'b1;
               state_nx = IDLE;
             end
      default: state_nx = IDLE;
    endcase
  end

  // DMA datapath. CAPT always follows a granted READ, so the data on
  // vram_rdata in CAPT is always the DMA read, whatever owns the port now.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      src     <= '0;
      dst     <= '0;
      cnt     <= '0;
      dma_buf <= '0;
    end else begin
      if (state == IDLE && dma_start) begin
        src <= dma_src;
        dst <= dma_dst;
        cnt <= dma_len;
      end
      if (state == CAPT) dma_buf <= vram.vram_rdata;
      if (dma_wr_go) begin
        src <= dma_src_dec ? src - AW'(1) : src + AW'(1);
        dst <= dma_dst_dec ? dst - AW'(1) : dst + AW'(1);
        if (cnt != '0) cnt <= cnt - AW'(1);
      end
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter -- directed bench for vram_arbiter. Stimulus pushes each
// expected VRAM bus access into a queue. A monitor pops an entry and compares
// it whenever the DUT drives vram_re or vram_we. Status outputs are checked
// inline against hand-computed values. The memory model returns 0x1234 at
// 0xFFFF and addr ^ 0xA5A5 everywhere else.
module tb_vram_arbiter;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
  } acc_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        render_req, render_grant;
  logic [15:0] render_addr;
  logic        mawr_ld, cpu_wr_req, marr_ld, cpu_rd_ack;
  logic [15:0] mawr_in, cpu_wr_data, marr_in, vrr_data;
  logic [1:0]  incr_sel;
  logic        busy_n;
  logic        dma_start, dma_src_dec, dma_dst_dec, dma_busy, dma_done;
  logic [15:0] dma_src, dma_dst, dma_len;

  acc_t exp_q[$];
  acc_t mon_e;
  int   total = 0;
  int   bad   = 0;

  vram_arbiter_if #(.AW(16), .DW(16)) bus ();

  vram_arbiter #(.AW(16), .DW(16)) dut (
    .clock(clock), .reset(reset),
    .render_req(render_req), .render_addr(render_addr), .render_grant(render_grant),
    .mawr_ld(mawr_ld), .mawr_in(mawr_in), .cpu_wr_req(cpu_wr_req), .cpu_wr_data(cpu_wr_data),
    .marr_ld(marr_ld), .marr_in(marr_in), .cpu_rd_ack(cpu_rd_ack), .vrr_data(vrr_data),
    .incr_sel(incr_sel), .busy_n(busy_n),
    .dma_start(dma_start), .dma_src(dma_src), .dma_dst(dma_dst), .dma_len(dma_len),
    .dma_src_dec(dma_src_dec), .dma_dst_dec(dma_dst_dec),
    .dma_busy(dma_busy), .dma_done(dma_done),
    .vram(bus)
  );

  always #5 clock = ~clock;

  function automatic logic [15:0] rd_model(input logic [15:0] a);
    return (a == 16'hFFFF) ? 16'h1234 : (a ^ 16'hA5A5);
  endfunction

  // Memory model: read data appears the cycle after vram_re.
  always @(posedge clock) begin
    if (bus.vram_re) bus.vram_rdata <= rd_model(bus.vram_addr);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic exp_rd(input logic [15:0] a);
    acc_t e;
    e.we = 1'b0; e.addr = a; e.wdata = 16'h0000;
    exp_q.push_back(e);
  endtask

  task automatic exp_wr(input logic [15:0] a, input logic [15:0] d);
    acc_t e;
    e.we = 1'b1; e.addr = a; e.wdata = d;
    exp_q.push_back(e);
  endtask

  task automatic wait_done(output int n);
    n = 1;
    while (dma_done !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    if (dma_done !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL dma_timeout: got dma_done=%b after %0d cycles want 1", dma_done, n);
    end
  endtask

  // Bus monitor, sampled mid-cycle, away from the active edge.
  always @(negedge clock) begin
    if (reset === 1'b0 && (bus.vram_re === 1'b1 || bus.vram_we === 1'b1)) begin
      check("bus_re_we_excl", {31'b0, bus.vram_re & bus.vram_we}, 32'd0);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL bus_unexpected: got we=%b addr=%h want no access",
                 bus.vram_we, bus.vram_addr);
      end else begin
        mon_e = exp_q.pop_front();
        check("bus_kind", {31'b0, bus.vram_we}, {31'b0, mon_e.we});
        check("bus_addr", {16'b0, bus.vram_addr}, {16'b0, mon_e.addr});
        if (mon_e.we) check("bus_wdata", {16'b0, bus.vram_wdata}, {16'b0, mon_e.wdata});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  n;
    logic saw;
    reset = 1'b1; render_req = 1'b1; render_addr = 16'h0ABC;
    mawr_ld = 0; mawr_in = 0; cpu_wr_req = 0; cpu_wr_data = 0;
    marr_ld = 0; marr_in = 0; cpu_rd_ack = 0; incr_sel = 2'b00;
    dma_start = 0; dma_src = 0; dma_dst = 0; dma_len = 0;
    dma_src_dec = 0; dma_dst_dec = 0;
    #1;
    check("rst_render_grant", {31'b0, render_grant}, 32'd1);
    check("rst_vram_we", {31'b0, bus.vram_we}, 32'd0);
    check("rst_busy_n", {31'b0, busy_n}, 32'd1);
    check("rst_dma_busy", {31'b0, dma_busy}, 32'd0);
    check("rst_dma_done", {31'b0, dma_done}, 32'd0);
    check("rst_vrr_data", {16'b0, vrr_data}, 32'd0);
    tick(); tick();
    reset = 1'b0; render_req = 1'b0;
    tick();

    // A: write through the pointer with a step of 32.
    mawr_ld = 1; mawr_in = 16'h1000; incr_sel = 2'b01; tick();
    mawr_ld = 0; cpu_wr_req = 1; cpu_wr_data = 16'hABCD; exp_wr(16'h1000, 16'hABCD);
    check("a_busy_before", {31'b0, busy_n}, 32'd1); tick();
    cpu_wr_req = 0; check("a_busy_low", {31'b0, busy_n}, 32'd0); tick();
    check("a_busy_high", {31'b0, busy_n}, 32'd1);
    cpu_wr_req = 1; cpu_wr_data = 16'h1111; exp_wr(16'h1020, 16'h1111); tick();
    cpu_wr_req = 0; tick(); tick();

    // B: render holds the port for 3 cycles; the write goes out on cycle 4.
    incr_sel = 2'b00;
    render_req = 1; render_addr = 16'h0A00; cpu_wr_req = 1; cpu_wr_data = 16'h2222;
    exp_rd(16'h0A00); exp_rd(16'h0A01); exp_rd(16'h0A02); exp_wr(16'h1040, 16'h2222);
    check("b_grant1", {31'b0, render_grant}, 32'd1); tick();
    cpu_wr_req = 0; render_addr = 16'h0A01;
    check("b_grant2", {31'b0, render_grant}, 32'd1);
    check("b_busy2", {31'b0, busy_n}, 32'd0); tick();
    render_addr = 16'h0A02;
    check("b_grant3", {31'b0, render_grant}, 32'd1);
    check("b_busy3", {31'b0, busy_n}, 32'd0); tick();
    render_req = 0; #1;
    check("b_grant4", {31'b0, render_grant}, 32'd0);
    check("b_busy4", {31'b0, busy_n}, 32'd0);
    check("b_we4", {31'b0, bus.vram_we}, 32'd1); tick();
    check("b_busy5", {31'b0, busy_n}, 32'd1);

    // C: prefetch at 0xFFFF, then advance; the pointer wraps to 0x0000.
    marr_ld = 1; marr_in = 16'hFFFF; exp_rd(16'hFFFF); tick();
    marr_ld = 0; check("c_busy_issue", {31'b0, busy_n}, 32'd0); tick();
    check("c_busy_return", {31'b0, busy_n}, 32'd0); tick();
    check("c_vrr", {16'b0, vrr_data}, 32'h1234);
    check("c_busy_idle", {31'b0, busy_n}, 32'd1);
    cpu_rd_ack = 1; exp_rd(16'h0000); tick();
    cpu_rd_ack = 0; tick(); tick();
    check("c_vrr2", {16'b0, vrr_data}, 32'hA5A5);

    // D: uncontended DMA of 3 words, 3 cycles per word plus DONE.
    dma_src = 16'h0010; dma_dst = 16'h0100; dma_len = 16'd2; dma_start = 1;
    exp_rd(16'h0010); exp_wr(16'h0100, 16'hA5B5);
    exp_rd(16'h0011); exp_wr(16'h0101, 16'hA5B4);
    exp_rd(16'h0012); exp_wr(16'h0102, 16'hA5B7);
    tick(); dma_start = 0;
    check("d_busy", {31'b0, dma_busy}, 32'd1);
    wait_done(n);
    check("d_cycles", n, 32'd10);
    check("d_busy_done", {31'b0, dma_busy}, 32'd1);
    tick();
    check("d_done_pulse", {31'b0, dma_done}, 32'd0);
    check("d_idle", {31'b0, dma_busy}, 32'd0);

    // E: decrementing destination wraps 0x0000 to 0xFFFF while CPU reads
    // are interleaved with the transfer.
    dma_src = 16'h0020; dma_dst = 16'h0000; dma_len = 16'd1; dma_dst_dec = 1;
    dma_start = 1; marr_ld = 1; marr_in = 16'h0300;
    exp_rd(16'h0300); exp_rd(16'h0020); exp_rd(16'h0301);
    exp_wr(16'h0000, 16'hA585); exp_rd(16'h0021); exp_wr(16'hFFFF, 16'hA584);
    tick(); dma_start = 0; marr_ld = 0;
    tick(); cpu_rd_ack = 1;
    tick(); cpu_rd_ack = 0;
    check("e_busy", {31'b0, busy_n}, 32'd0);
    tick(); tick();
    check("e_vrr", {16'b0, vrr_data}, 32'hA6A4);
    wait_done(n);
    check("e_vrr_intact", {16'b0, vrr_data}, 32'hA6A4);
    tick();
    check("e_idle", {31'b0, dma_busy}, 32'd0);
    dma_dst_dec = 0;

    // F: reset while DMA waits in WRITE behind render.
    dma_src = 16'h0040; dma_dst = 16'h0200; dma_len = 16'd0; dma_start = 1;
    exp_rd(16'h0040); tick();
    dma_start = 0; tick();
    render_req = 1; render_addr = 16'h0B00; exp_rd(16'h0B00);
    check("f_busy", {31'b0, dma_busy}, 32'd1); tick();
    reset = 1; #1;
    check("f_rst_dma_busy", {31'b0, dma_busy}, 32'd0);
    check("f_rst_dma_done", {31'b0, dma_done}, 32'd0);
    check("f_rst_we", {31'b0, bus.vram_we}, 32'd0);
    check("f_rst_grant", {31'b0, render_grant}, 32'd1);
    check("f_rst_busy_n", {31'b0, busy_n}, 32'd1);
    tick(); tick();
    reset = 0; render_req = 0;
    saw = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (dma_done !== 1'b0 || bus.vram_we !== 1'b0) saw = 1'b1;
    end
    check("f_no_activity", {31'b0, saw}, 32'd0);

    // H: the write pointer was cleared by reset.
    cpu_wr_req = 1; cpu_wr_data = 16'h5555; exp_wr(16'h0000, 16'h5555); tick();
    cpu_wr_req = 0; tick(); tick();

    // G: second request while full is dropped; the load redirects the pending write.
    render_req = 1; render_addr = 16'h0C00; cpu_wr_req = 1; cpu_wr_data = 16'h3333;
    exp_rd(16'h0C00); exp_rd(16'h0C01); exp_wr(16'h2000, 16'h3333); tick();
    render_addr = 16'h0C01; cpu_wr_data = 16'h4444; mawr_ld = 1; mawr_in = 16'h2000; tick();
    render_req = 0; cpu_wr_req = 0; mawr_ld = 0; tick(); tick();
    cpu_wr_req = 1; cpu_wr_data = 16'h6666; exp_wr(16'h2001, 16'h6666); tick();
    cpu_wr_req = 0; tick(); tick();

    check("queue_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 SHALL have parameter AW, default 16, VRAM word-address width.
REQ-002 SHALL have parameter DW, default 16, VRAM data width.
REQ-003 SHALL have ports: clock  in  1  sole clock; all state on rising edge.
REQ-004 SHALL have port: reset  in  1  asynchronous, active-high.
REQ-005 SHALL have ports: render_req in 1 render fetch request; render_addr in AW fetch address; render_grant out 1 port granted to render this cycle.
REQ-006 SHALL have ports: mawr_ld in 1 load write pointer; mawr_in in AW; cpu_wr_req in 1 VWR MSB written, 1-cycle pulse; cpu_wr_data in DW.
REQ-007 SHALL have ports: marr_ld in 1 load read pointer and prefetch; marr_in in AW; cpu_rd_ack in 1 VRR MSB read, 1-cycle pulse; vrr_data out DW prefetched read word.
REQ-008 SHALL have ports: incr_sel in 2 pointer step, 00=1, 01=32, 10=64, 11=128; busy_n out 1 low while a CPU access is outstanding.
REQ-009 SHALL have ports: dma_start in 1 pulse; dma_src, dma_dst, dma_len in AW each; dma_src_dec, dma_dst_dec in 1 each, 1=decrement; dma_busy out 1; dma_done out 1, 1-cycle pulse.
REQ-010 SHALL have ports: vram_addr out AW; vram_re out 1; vram_we out 1; vram_wdata out DW; vram_rdata in DW, valid the cycle after vram_re.

Function
REQ-011 SHALL issue at most one VRAM access per cycle, fixed priority: render > CPU write > CPU read > DMA.
REQ-012 SHALL assert render_grant and vram_re with vram_addr=render_addr combinationally whenever render_req=1; render data is not captured.
REQ-013 cpu_wr_req SHALL latch cpu_wr_data into a 1-entry buffer and set wr_pending; cpu_wr_req while wr_pending=1 SHALL be ignored.
REQ-014 Serviced write SHALL drive vram_we=1, vram_addr=MAWR, vram_wdata=buffer, then MAWR+=step and clear wr_pending in the same edge.
REQ-015 mawr_ld SHALL load MAWR and take precedence over an increment in the same cycle; a pending write uses the updated MAWR.
REQ-016 marr_ld SHALL load MARR and set rd_pending; cpu_rd_ack SHALL add step to MARR and set rd_pending; both in one cycle: marr_ld wins, no increment.
REQ-017 Serviced read SHALL drive vram_re=1, vram_addr=MARR, clear rd_pending, and load vrr_data from vram_rdata one cycle later.
REQ-018 busy_n SHALL be 0 while wr_pending, rd_pending, or a CPU read return cycle is in flight; otherwise 1.
REQ-019 A 1-bit return tag SHALL route the data-return cycle to vrr_data (CPU) or the DMA buffer; render returns are not captured.
REQ-020 DMA FSM states SHALL be IDLE, READ, CAPT, WRITE, DONE.
REQ-021 IDLE: dma_start SHALL load SRC, DST, CNT=dma_len and go to READ; dma_start outside IDLE SHALL be ignored.
REQ-022 READ SHALL wait until DMA holds the port, then issue vram_re at SRC and go to CAPT.
REQ-023 CAPT SHALL capture vram_rdata into the DMA buffer regardless of the current grant, then go to WRITE.
REQ-024 WRITE SHALL wait for the port, then write the buffer to DST and step SRC and DST by ±1 per the dec bits.
REQ-025 On that WRITE, CNT=0 SHALL go to DONE; otherwise CNT-=1 and go to READ; total transfer is dma_len+1 words.
REQ-026 DONE SHALL pulse dma_done for one cycle and return to IDLE; dma_busy=1 in every state except IDLE.
REQ-027 All pointer arithmetic SHALL wrap modulo 2^AW (0xFFFF+1=0x0000, 0x0000-1=0xFFFF); step SHALL be zero-extended.
REQ-028 vram_re and vram_we SHALL never both be 1; with no grant, vram_re=vram_we=0, vram_addr=0, vram_wdata=0.

Reset
REQ-029 reset SHALL clear MAWR, MARR, buffers, vrr_data, SRC, DST, CNT, pending flags and tag to 0; FSM to IDLE.
REQ-030 During reset: busy_n=1, dma_busy=0, dma_done=0, render_grant follows render_req, vram_we=0.
REQ-031 Reset mid-DMA SHALL abort with no dma_done and no further VRAM write.

Verification
REQ-032 mawr_ld 0x1000, incr_sel=01, cpu_wr_req 0xABCD -> write 0xABCD@0x1000 next cycle; MAWR=0x1020; busy_n low exactly 1 cycle.
REQ-033 render_req held 3 cycles with cpu_wr_req pending -> render_grant 3 cycles, write issued on 4th cycle, busy_n low until then.
REQ-034 marr_ld 0xFFFF, rdata=0x1234, then cpu_rd_ack with incr_sel=00 -> vrr_data=0x1234; MARR=0x0000; second fetch at 0x0000.
REQ-035 DMA src=0x0010, dst=0x0100, len=2, no contention -> 3 words copied, 3 cycles/word, dma_done pulse 1 cycle, FSM IDLE.
REQ-036 DMA dst_dec=1, dst=0x0000, len=1 with interleaved CPU reads -> writes to 0x0000 then 0xFFFF; CPU data intact.
REQ-037 Assert reset during DMA WRITE wait -> no vram_we, dma_busy=0, dma_done never pulses.
